// File: rtl/gp_axis_pkg.sv
// Shared FSM encoding and bank count for the AXIS ping-pong front end.
// GP_AXIS_PINGPONG_EN selects two input banks; otherwise one bank is used.
package gp_axis_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

`ifdef GP_AXIS_PINGPONG_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

endpackage

// File: rtl/gp_axis_bank_ram.sv
// Small buffer RAM: synchronous write, asynchronous read.
// Out-of-range writes are dropped and out-of-range reads return zero.
module gp_axis_bank_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  wr,
  input  logic [ADR_WIDTH-1:0]  wr_adr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADR_WIDTH-1:0]  rd_adr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_in_range;
  logic                  rd_in_range;

  assign wr_in_range = (wr_adr < ADR_WIDTH'(DEPTH));
  assign rd_in_range = (rd_adr < ADR_WIDTH'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr && wr_in_range) begin
      mem[wr_adr[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_in_range ? mem[rd_adr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/gp_axis_pingpong_if.sv
// AXI-Stream front end for accelerator wrappers: input frames land in ping-pong
// banks (GP_AXIS_PINGPONG_EN) or a single bank, and the output buffer drains to m_*.
module gp_axis_pingpong_if
  import gp_axis_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int IN_DATA_NUM   = 8,
  parameter int OUT_DATA_NUM  = 4,
  parameter int IN_ADR_WIDTH  = 8,
  parameter int OUT_ADR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     axisif_start,
  input  logic                     axisif_done,
  input  logic [IN_ADR_WIDTH-1:0]  axisif_bufferIn_adr,
  output logic [DATA_WIDTH-1:0]    axisif_bufferIn_data,
  output logic [IN_ADR_WIDTH-1:0]  axisif_bufferIn_len,
  input  logic [OUT_ADR_WIDTH-1:0] axisif_bufferOut_adr,
  input  logic [DATA_WIDTH-1:0]    axisif_bufferOut_data,
  input  logic                     axisif_bufferOut_wr,
  output logic                     err_len,
  input  logic                     err_clr
);

  // Handshakes: a beat moves on s_valid & s_ready or m_valid & m_ready at a
  // rising edge; a source holds data/last stable until its beat is taken.

  state_t                   state;
  state_t                   next_state;
  logic [1:0]               full;
  logic [IN_ADR_WIDTH-1:0]  len [2];
  logic                     wr_bank;
  logic                     rd_bank;
  logic [IN_ADR_WIDTH-1:0]  cnt;
  logic [OUT_ADR_WIDTH-1:0] ocnt;
  logic                     beat_acc;
  logic                     cnt_end;
  logic                     frame_close;
  logic                     len_err;
  logic                     bank_release;
  logic                     outbuf_wr;
  logic [DATA_WIDTH-1:0]    bank_rd [2];

  assign s_ready     = ~rst & ~full[wr_bank];
  assign beat_acc    = s_valid & s_ready;
  assign cnt_end     = (cnt == IN_ADR_WIDTH'(IN_DATA_NUM - 1));
  assign frame_close = beat_acc & (s_last | cnt_end);
  // Early s_last and a count-close without s_last are both length errors.
  assign len_err     = beat_acc & (s_last ^ cnt_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      wr_bank <= 1'b0;
      len[0]  <= '0;
      len[1]  <= '0;
      err_len <= 1'b0;
    end else begin
      if (frame_close) begin
        cnt          <= '0;
        len[wr_bank] <= cnt + 1'b1;
        if (NUM_BANKS > 1) wr_bank <= ~wr_bank;
      end else if (beat_acc) begin
        cnt <= cnt + 1'b1;
      end
      if (len_err) begin
        err_len <= 1'b1;
      end else if (err_clr) begin
        err_len <= 1'b0;
      end
    end
  end

  // A close only targets an empty bank and a release only a full one, so the
  // two never collide on the same bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= '0;
      rd_bank <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (frame_close && (wr_bank == 1'(b))) begin
          full[b] <= 1'b1;
        end else if (bank_release && (rd_bank == 1'(b))) begin
          full[b] <= 1'b0;
        end
      end
      if (bank_release && (NUM_BANKS > 1)) rd_bank <= ~rd_bank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ocnt  <= '0;
    end else begin
      state <= next_state;
      if (m_valid && m_ready) begin
        ocnt <= m_last ? '0 : ocnt + 1'b1;
      end
    end
  end

  always_comb begin
    next_state   = state;
    axisif_start = 1'b0;
    m_valid      = 1'b0;
    m_last       = 1'b0;
    bank_release = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) next_state = START;
      end
      START: begin
        axisif_start = 1'b1;
        next_state   = BUSY;
      end
      BUSY: begin
        if (axisif_done) begin
          bank_release = 1'b1;
          next_state   = DRAIN;
        end
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_last  = (ocnt == OUT_ADR_WIDTH'(OUT_DATA_NUM - 1));
        if (m_ready && m_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NUM_BANKS) begin : g_ram
      gp_axis_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IN_DATA_NUM),
        .ADR_WIDTH  (IN_ADR_WIDTH)
      ) u_bank (
        .clk     (clk),
        .wr      (beat_acc & (wr_bank == 1'(b))),
        .wr_adr  (cnt),
        .wr_data (s_data),
        .rd_adr  (axisif_bufferIn_adr),
        .rd_data (bank_rd[b])
      );
    end else begin : g_none
      assign bank_rd[b] = '0;
    end
  end

  assign axisif_bufferIn_data = bank_rd[rd_bank];
  assign axisif_bufferIn_len  = len[rd_bank];

  // Wrapper writes only count while it owns the output buffer.
  assign outbuf_wr = axisif_bufferOut_wr & (state == BUSY);

  gp_axis_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OUT_DATA_NUM),
    .ADR_WIDTH  (OUT_ADR_WIDTH)
  ) u_outbuf (
    .clk     (clk),
    .wr      (outbuf_wr),
    .wr_adr  (axisif_bufferOut_adr),
    .wr_data (axisif_bufferOut_data),
    .rd_adr  (ocnt),
    .rd_data (m_data)
  );

endmodule

// File: tb/tb_gp_axis_pingpong_if.sv
// Directed bench for gp_axis_pingpong_if; works with or without GP_AXIS_PINGPONG_EN.
module tb_gp_axis_pingpong_if;

  localparam int DW    = 32;
  localparam int IN_N  = 8;
  localparam int OUT_N = 4;
  localparam int IAW   = 8;
  localparam int OAW   = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  s_data;
  logic           s_valid;
  logic           s_last;
  logic           s_ready;
  logic [DW-1:0]  m_data;
  logic           m_valid;
  logic           m_last;
  logic           m_ready;
  logic           axisif_start;
  logic           axisif_done;
  logic [IAW-1:0] axisif_bufferIn_adr;
  logic [DW-1:0]  axisif_bufferIn_data;
  logic [IAW-1:0] axisif_bufferIn_len;
  logic [OAW-1:0] axisif_bufferOut_adr;
  logic [DW-1:0]  axisif_bufferOut_data;
  logic           axisif_bufferOut_wr;
  logic           err_len;
  logic           err_clr;

  gp_axis_pingpong_if #(
    .DATA_WIDTH    (DW),
    .IN_DATA_NUM   (IN_N),
    .OUT_DATA_NUM  (OUT_N),
    .IN_ADR_WIDTH  (IAW),
    .OUT_ADR_WIDTH (OAW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .s_data                (s_data),
    .s_valid               (s_valid),
    .s_last                (s_last),
    .s_ready               (s_ready),
    .m_data                (m_data),
    .m_valid               (m_valid),
    .m_last                (m_last),
    .m_ready               (m_ready),
    .axisif_start          (axisif_start),
    .axisif_done           (axisif_done),
    .axisif_bufferIn_adr   (axisif_bufferIn_adr),
    .axisif_bufferIn_data  (axisif_bufferIn_data),
    .axisif_bufferIn_len   (axisif_bufferIn_len),
    .axisif_bufferOut_adr  (axisif_bufferOut_adr),
    .axisif_bufferOut_data (axisif_bufferOut_data),
    .axisif_bufferOut_wr   (axisif_bufferOut_wr),
    .err_len               (err_len),
    .err_clr               (err_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int starts_seen = 0;

  logic [DW-1:0]  exp_q[$];
  logic           exp_last_q[$];
  logic [DW-1:0]  in_q[$];
  logic [IAW-1:0] len_q[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // output monitor: start counting, hold-while-stalled, scoreboard pop
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic          pl = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (axisif_start) start_cnt++;
      if (pv && !pr) begin
        check("m_hold_valid", DW'(m_valid), DW'(1));
        check("m_hold_data", m_data, pd);
        check("m_hold_last", DW'(m_last), DW'(pl));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("m_extra_beat", DW'(exp_q.size() + 1), DW'(0));
        end else begin
          logic [DW-1:0] e;
          logic          el;
          e  = exp_q.pop_front();
          el = exp_last_q.pop_front();
          check("m_data", m_data, e);
          check("m_last", DW'(m_last), DW'(el));
        end
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      pl = m_last;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last, output int waited);
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    waited  = 0;
    @(negedge clk);
    while (!s_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!s_ready) check("s_ready_timeout", DW'(s_ready), DW'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_run(input int base, input int n, input logic last_end, input logic nostall);
    for (int i = 0; i < n; i++) begin
      int w;
      send_beat(DW'(base + i), last_end && (i == n - 1), w);
      in_q.push_back(DW'(base + i));
      if (nostall) check("no_stall", DW'(w), DW'(0));
    end
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (start_cnt <= starts_seen && t < 100) begin
      tick();
      t++;
    end
    check("start_seen", DW'(start_cnt), DW'(starts_seen + 1));
    starts_seen = starts_seen + 1;
  endtask

  task automatic check_inputs();
    logic [IAW-1:0] n;
    n = len_q.pop_front();
    check("in_len", DW'(axisif_bufferIn_len), DW'(n));
    for (int i = 0; i < int'(n); i++) begin
      axisif_bufferIn_adr = IAW'(i);
      @(negedge clk);
      check("in_data", axisif_bufferIn_data, in_q.pop_front());
    end
    tick();
  endtask

  task automatic write_out(input logic [DW-1:0] obase);
    for (int i = 0; i < OUT_N; i++) begin
      axisif_bufferOut_adr  = OAW'(i);
      axisif_bufferOut_data = obase + DW'(i);
      axisif_bufferOut_wr   = 1'b1;
      tick();
      exp_q.push_back(obase + DW'(i));
      exp_last_q.push_back(i == OUT_N - 1);
    end
    axisif_bufferOut_wr = 1'b0;
  endtask

  task automatic finish_compute(input logic blocked);
    repeat (5) tick();
    if (blocked) begin
      @(negedge clk);
      check("s_ready_blocked", DW'(s_ready), DW'(0));
      tick();
    end
    axisif_done = 1'b1;
    tick();
    axisif_done = 1'b0;
    if (blocked) begin
      @(negedge clk);
      check("s_ready_after_done", DW'(s_ready), DW'(1));
      tick();
    end
  endtask

  task automatic drain(input logic [3:0] pat);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 60) begin
      m_ready = pat[t % 4];
      tick();
      t++;
    end
    m_ready = 1'b0;
    check("drain_left", DW'(exp_q.size()), DW'(0));
    @(negedge clk);
    check("m_valid_idle", DW'(m_valid), DW'(0));
    tick();
  endtask

  task automatic process(input logic blocked, input logic [DW-1:0] obase,
                         input logic [3:0] pat, input logic garbage);
    wait_start();
    check_inputs();
    write_out(obase);
    finish_compute(blocked);
    if (garbage) begin
      // write during DRAIN must not reach the output buffer
      axisif_bufferOut_adr  = OAW'(OUT_N - 1);
      axisif_bufferOut_data = 32'hDEAD_BEEF;
      axisif_bufferOut_wr   = 1'b1;
      tick();
      axisif_bufferOut_wr = 1'b0;
    end
    drain(pat);
  endtask

  initial begin
    int w;
    rst = 1'b0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    axisif_done = 1'b0; axisif_bufferIn_adr = '0; axisif_bufferOut_adr = '0;
    axisif_bufferOut_data = '0; axisif_bufferOut_wr = 1'b0; err_clr = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_s_ready", DW'(s_ready), DW'(0));
    check("rst_m_valid", DW'(m_valid), DW'(0));
    check("rst_m_last", DW'(m_last), DW'(0));
    check("rst_start", DW'(axisif_start), DW'(0));
    check("rst_len", DW'(axisif_bufferIn_len), DW'(0));
    check("rst_err", DW'(err_len), DW'(0));
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("s_ready_after_rst", DW'(s_ready), DW'(1));

    // two full 8-beat frames, start latency, outbuf A..D with m_ready 1,0,1,0
    send_run(1, 8, 1'b1, 1'b1);
    len_q.push_back(IAW'(8));
    @(negedge clk);
    check("start_lat_c1", DW'(axisif_start), DW'(0));
    @(negedge clk);
    check("start_lat_c2", DW'(axisif_start), DW'(1));
    tick();
`ifdef GP_AXIS_PINGPONG_EN
    send_run(9, 8, 1'b1, 1'b1);
    len_q.push_back(IAW'(8));
    process(1'b1, 32'hA, 4'b0101, 1'b1);
    process(1'b0, 32'h100, 4'b1111, 1'b0);
`else
    process(1'b1, 32'hA, 4'b0101, 1'b1);
    send_run(9, 8, 1'b1, 1'b1);
    len_q.push_back(IAW'(8));
    process(1'b1, 32'h100, 4'b1111, 1'b0);
`endif
    check("err_after_full_frames", DW'(err_len), DW'(0));
    check("start_count_2", DW'(start_cnt), DW'(2));

    // short frame: early s_last sets err_len, err_clr clears it
    send_run(32'h20, 3, 1'b1, 1'b1);
    len_q.push_back(IAW'(3));
    @(negedge clk);
    check("err_short", DW'(err_len), DW'(1));
    tick();
    process(1'b0, 32'h200, 4'b1111, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", DW'(err_len), DW'(0));
    tick();

    // 10 beats without s_last; err_clr collides with the count-close beat
    send_run(32'h30, 7, 1'b0, 1'b1);
    err_clr = 1'b1;
    send_run(32'h37, 1, 1'b0, 1'b1);
    err_clr = 1'b0;
    len_q.push_back(IAW'(8));
    @(negedge clk);
    check("err_count_close", DW'(err_len), DW'(1));
    tick();
`ifdef GP_AXIS_PINGPONG_EN
    send_run(32'h38, 2, 1'b0, 1'b1);
    process(1'b0, 32'h300, 4'b1111, 1'b0);
`else
    process(1'b1, 32'h300, 4'b1111, 1'b0);
    send_run(32'h38, 2, 1'b0, 1'b1);
`endif
    send_run(32'h3A, 1, 1'b1, 1'b1);
    len_q.push_back(IAW'(3));
    process(1'b0, 32'h400, 4'b0011, 1'b0);

    // reset mid-DRAIN with a partial frame queued
    send_run(32'h40, 4, 1'b1, 1'b1);
    len_q.push_back(IAW'(4));
    wait_start();
    check_inputs();
    write_out(32'h500);
    finish_compute(1'b0);
    send_beat(32'h60, 1'b0, w);
    send_beat(32'h61, 1'b0, w);
    @(negedge clk);
    check("m_valid_in_drain", DW'(m_valid), DW'(1));
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_s_ready", DW'(s_ready), DW'(0));
    check("mid_rst_m_valid", DW'(m_valid), DW'(0));
    check("mid_rst_m_last", DW'(m_last), DW'(0));
    check("mid_rst_start", DW'(axisif_start), DW'(0));
    check("mid_rst_len", DW'(axisif_bufferIn_len), DW'(0));
    check("mid_rst_err", DW'(err_len), DW'(0));
    exp_q.delete();
    exp_last_q.delete();
    in_q.delete();
    len_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("no_start_after_rst", DW'(start_cnt), DW'(starts_seen));
    send_run(32'h50, 4, 1'b1, 1'b1);
    len_q.push_back(IAW'(4));
    process(1'b0, 32'h600, 4'b1111, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
